// File: rtl/regfile_sweep.sv
// regfile_sweep: 32-entry register file, two comb reads, one clocked write.
// Reset clears the array by sweeping one register per cycle; Ready gates use.
//
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   WriteData/Register    write data and address, qualified by RegWrite
//   ReadRegister1/2       read addresses
//   ReadData1/2           combinational read data (zero while not Ready)
//   Ready                 array cleared, writes accepted
//   WriteDropped          one-cycle pulse: write requested during the sweep
module regfile_sweep #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       WriteRegister,
  input  logic             RegWrite,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             Ready,
  output logic             WriteDropped
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]       state;
  logic [4:0]       idx;
  logic [WIDTH-1:0] regs [32];

  // Entry 0 is never written; reads of address 0 are forced to zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= CLEAR;
      idx          <= 5'd1;
      Ready        <= 1'b0;
      WriteDropped <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          regs[idx]    <= '0;
          WriteDropped <= RegWrite;
          if (idx == 5'd31) begin
            state <= RUN;
            Ready <= 1'b1;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        RUN: begin
          WriteDropped <= 1'b0;
          if (RegWrite && WriteRegister != 5'd0)
            regs[WriteRegister] <= WriteData;
        end
        default: begin
          state        <= CLEAR;
          idx          <= 5'd1;
          Ready        <= 1'b0;
          WriteDropped <= 1'b0;
        end
      endcase
    end
  end

  logic wr_live;
  assign wr_live = Ready && RegWrite && (WriteRegister != 5'd0);

  always_comb begin
    ReadData1 = '0;
    if (Ready && ReadRegister1 != 5'd0) begin
      if (BYPASS && wr_live && WriteRegister == ReadRegister1)
        ReadData1 = WriteData;
      else
        ReadData1 = regs[ReadRegister1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (Ready && ReadRegister2 != 5'd0) begin
      if (BYPASS && wr_live && WriteRegister == ReadRegister2)
        ReadData2 = WriteData;
      else
        ReadData2 = regs[ReadRegister2];
    end
  end

endmodule

// File: tb/tb_regfile_sweep.sv
// tb_regfile_sweep: directed plan plus random traffic on two instances
// (no bypass / bypass) compared every cycle against a behavioural model.
module tb_regfile_sweep;

  logic        Clk;
  logic        Reset;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] rd1_n, rd2_n, rd1_b, rd2_b;
  logic        rdy_n, rdy_b, drop_n, drop_b;

  int total = 0;
  int bad   = 0;

  regfile_sweep #(.WIDTH(32), .BYPASS(1'b0)) dut_n (
    .Clk(Clk), .Reset(Reset),
    .WriteData(WriteData), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_n), .ReadData2(rd2_n),
    .Ready(rdy_n), .WriteDropped(drop_n)
  );

  regfile_sweep #(.WIDTH(32), .BYPASS(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .WriteData(WriteData), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_b), .ReadData2(rd2_b),
    .Ready(rdy_b), .WriteDropped(drop_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: user-visible state only. Since reads are masked and writes
  // dropped for the whole sweep, the array is simply all-zero at Ready.
  bit          active = 0;
  int          cnt = 0;
  bit          m_drop = 0;
  logic [31:0] mem [32];

  always @(posedge Clk) begin
    if (Reset) begin
      active = 1;
      cnt    = 0;
      m_drop = 0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
    end else if (active) begin
      if (cnt < 31) begin
        m_drop = RegWrite;
        cnt++;
      end else begin
        m_drop = 0;
        if (RegWrite && WriteRegister != 0)
          mem[WriteRegister] = WriteData;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                         input bit byp);
    if (cnt < 31 || a == 0) return '0;
    if (byp && RegWrite && WriteRegister != 0 && WriteRegister == a)
      return WriteData;
    return mem[a];
  endfunction

  always @(negedge Clk) begin
    if (active) begin
      check("ready_n", {31'b0, rdy_n}, {31'b0, cnt >= 31});
      check("ready_b", {31'b0, rdy_b}, {31'b0, cnt >= 31});
      check("drop_n", {31'b0, drop_n}, {31'b0, m_drop});
      check("drop_b", {31'b0, drop_b}, {31'b0, m_drop});
      check("rd1_n", rd1_n, exp_rd(ReadRegister1, 0));
      check("rd2_n", rd2_n, exp_rd(ReadRegister2, 0));
      check("rd1_b", rd1_b, exp_rd(ReadRegister1, 1));
      check("rd2_b", rd2_b, exp_rd(ReadRegister2, 1));
    end
  end

  task automatic edge1();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    edge1();
    RegWrite = 1'b0;
  endtask

  task automatic rd_both(input string name, input logic [31:0] e1,
                         input logic [31:0] e2);
    #1;
    check({name, "_p1"}, rd1_n, e1);
    check({name, "_p2"}, rd2_n, e2);
  endtask

  initial begin
    Reset = 1'b1;
    RegWrite = 1'b0;
    WriteData = '0;
    WriteRegister = '0;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd31;
    edge1();
    edge1();
    Reset = 1'b0;

    for (int i = 1; i <= 31; i++) begin
      edge1();
      check("sweep_ready", {31'b0, rdy_n}, {31'b0, i == 31});
      if (i < 31) rd_both("sweep_rd", 32'd0, 32'd0);
    end

    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd2;
    wr(5'd2, 32'd42);
    rd_both("r2_42", 32'd42, 32'd42);
    wr(5'd2, 32'd15);
    rd_both("r2_15", 32'd15, 32'd15);
    WriteData = 32'd42;
    edge1();
    rd_both("r2_hold", 32'd15, 32'd15);

    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    wr(5'd0, 32'd42);
    rd_both("r0", 32'd0, 32'd0);
    check("r0_nodrop", {31'b0, drop_n}, 32'd0);
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd3;
    rd_both("r3_fresh", 32'd0, 32'd0);

    wr(5'd3, 32'd427);
    wr(5'd4, 32'd563);
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd4;
    rd_both("r34", 32'd427, 32'd563);
    ReadRegister1 = 5'd4;
    ReadRegister2 = 5'd3;
    rd_both("r43", 32'd563, 32'd427);

    ReadRegister1 = 5'd9;
    WriteRegister = 5'd9;
    WriteData     = 32'hDEADBEEF;
    RegWrite      = 1'b1;
    #1;
    check("byp_on", rd1_b, 32'hDEADBEEF);
    check("byp_off", rd1_n, 32'd0);
    edge1();
    RegWrite = 1'b0;
    #1;
    check("byp_off_after", rd1_n, 32'hDEADBEEF);

    Reset = 1'b1;
    edge1();
    Reset = 1'b0;
    edge1();
    edge1();
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 32'd99;
    edge1();
    RegWrite = 1'b0;
    check("drop_pulse", {31'b0, drop_n}, 32'd1);
    edge1();
    check("drop_end", {31'b0, drop_n}, 32'd0);
    for (int i = 0; i < 40 && !rdy_n; i++) edge1();
    check("resweep_ready", {31'b0, rdy_n}, 32'd1);
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd3;
    rd_both("r7_r3_clr", 32'd0, 32'd0);
    ReadRegister1 = 5'd4;
    rd_both("r4_clr", 32'd0, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      Reset         = ($urandom_range(0, 299) == 0);
      RegWrite      = $urandom_range(0, 1);
      WriteRegister = $urandom_range(0, 3) == 0 ?
                      5'($urandom_range(0, 31)) :
                      5'($urandom_range(0, 7));
      WriteData     = $urandom;
      ReadRegister1 = $urandom_range(0, 2) == 0 ?
                      WriteRegister : 5'($urandom_range(0, 7));
      ReadRegister2 = $urandom_range(0, 2) == 0 ?
                      WriteRegister : 5'($urandom_range(0, 31));
      edge1();
    end
    Reset = 1'b0;
    RegWrite = 1'b0;
    edge1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
